// File: rtl/leaf_pkg.sv
// Shared constants and helpers for the leaf_interface user-side port blocks.
package leaf_pkg;

  localparam int PAYLOAD_BITS = 32;
  localparam int PACKET_BITS  = 49;
  localparam int CNT_BITS     = 16;
  localparam int FIFO_DEPTH   = 4;

  typedef logic [PAYLOAD_BITS-1:0] payload_t;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/leaf_port_fifo.sv
// Small synchronous FIFO with registered level and a look-ahead full flag so the
// owner can register its ack/ready without a combinational path to the output.
module leaf_port_fifo
  import leaf_pkg::*;
#(
  parameter int WIDTH = PAYLOAD_BITS,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full_next
);

  localparam int PTR_BITS = clog2(DEPTH);
  localparam int LVL_BITS = PTR_BITS + 1;
  localparam logic [LVL_BITS-1:0] FULL_LEVEL = LVL_BITS'(DEPTH);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_BITS-1:0] level_q, level_d;
  logic                full;
  logic                do_push;
  logic                do_pop;

  assign full      = (level_q == FULL_LEVEL);
  assign empty     = (level_q == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem_q[rd_ptr_q];
  assign full_next = (level_d == FULL_LEVEL);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_BITS'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
    end
    if (do_push && !do_pop) begin
      level_d = level_q + LVL_BITS'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LVL_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/leaf_user_port_adapter.sv
// User-side endpoint of a leaf_interface port pair: vld/ack <-> valid/ready through
// one FIFO per direction, plus wrap-around debug word counters.
module leaf_user_port_adapter #(
  parameter int PAYLOAD_BITS = leaf_pkg::PAYLOAD_BITS,
  parameter int FIFO_DEPTH   = leaf_pkg::FIFO_DEPTH,
  parameter int CNT_BITS     = leaf_pkg::CNT_BITS
) (
  input  logic                    clk_user,
  input  logic                    reset_n,
  input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user,
  input  logic                    vld_interface2user,
  output logic                    ack_user2interface,
  output logic [PAYLOAD_BITS-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  input  logic [PAYLOAD_BITS-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface,
  output logic                    vld_user2interface,
  input  logic                    ack_interface2user,
  output logic [CNT_BITS-1:0]     rx_count,
  output logic [CNT_BITS-1:0]     tx_count
);

  import leaf_pkg::*;

  logic                ack_q, ack_d;
  logic                s_ready_q, s_ready_d;
  logic [CNT_BITS-1:0] rx_count_q, rx_count_d;
  logic [CNT_BITS-1:0] tx_count_q, tx_count_d;
  logic                rx_push, rx_pop, rx_empty, rx_full_next;
  logic                tx_push, tx_pop, tx_empty, tx_full_next;

  assign rx_push = vld_interface2user & ack_q;
  assign rx_pop  = m_valid & m_ready;
  assign tx_push = s_valid & s_ready_q;
  assign tx_pop  = vld_user2interface & ack_interface2user;

  leaf_port_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk_user),
    .rst_n     (reset_n),
    .push      (rx_push),
    .pop       (rx_pop),
    .push_data (dout_leaf_interface2user),
    .head_data (m_data),
    .empty     (rx_empty),
    .full_next (rx_full_next)
  );

  leaf_port_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk_user),
    .rst_n     (reset_n),
    .push      (tx_push),
    .pop       (tx_pop),
    .push_data (s_data),
    .head_data (din_leaf_user2interface),
    .empty     (tx_empty),
    .full_next (tx_full_next)
  );

  assign m_valid            = ~rx_empty;
  assign vld_user2interface = ~tx_empty;
  assign ack_user2interface = ack_q;
  assign s_ready            = s_ready_q;
  assign rx_count           = rx_count_q;
  assign tx_count           = tx_count_q;

  // Flags follow the FIFO's next level so they drop in the same cycle it fills.
  always_comb begin
    ack_d      = ~rx_full_next;
    s_ready_d  = ~tx_full_next;
    rx_count_d = rx_count_q;
    tx_count_d = tx_count_q;
    if (rx_push) rx_count_d = rx_count_q + CNT_BITS'(1);
    if (tx_pop)  tx_count_d = tx_count_q + CNT_BITS'(1);
  end

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      ack_q      <= 1'b0;
      s_ready_q  <= 1'b0;
      rx_count_q <= '0;
      tx_count_q <= '0;
    end else begin
      ack_q      <= ack_d;
      s_ready_q  <= s_ready_d;
      rx_count_q <= rx_count_d;
      tx_count_q <= tx_count_d;
    end
  end

endmodule

// File: tb/tb_leaf_user_port_adapter.sv
// Randomized self-checking bench for leaf_user_port_adapter against a queue-based
// reference model of the two buffered directions and the debug counters.
module tb_leaf_user_port_adapter;

   localparam int PAYLOAD_BITS = 32;
   localparam int FIFO_DEPTH   = 4;
   localparam int CNT_BITS     = 4;
   localparam int CNT_MOD      = 1 << CNT_BITS;

   logic                    clkUser = 1'b0;
   logic                    resetN = 1'b1;
   logic [PAYLOAD_BITS-1:0] doutIf2User = '0;
   logic                    vldIf2User = 1'b0;
   logic                    ackUser2If;
   logic [PAYLOAD_BITS-1:0] mData;
   logic                    mValid;
   logic                    mReady = 1'b0;
   logic [PAYLOAD_BITS-1:0] sData = '0;
   logic                    sValid = 1'b0;
   logic                    sReady;
   logic [PAYLOAD_BITS-1:0] dinUser2If;
   logic                    vldUser2If;
   logic                    ackIf2User = 1'b0;
   logic [CNT_BITS-1:0]     rxCount;
   logic [CNT_BITS-1:0]     txCount;

   int assertCount = 0;
   int failCount = 0;

   logic [PAYLOAD_BITS-1:0] rxModel[$];
   logic [PAYLOAD_BITS-1:0] txModel[$];
   int                      rxCountModel = 0;
   int                      txCountModel = 0;
   bit                      outOfReset = 1'b0;

   bit                      rxPending = 1'b0;
   logic [PAYLOAD_BITS-1:0] rxPendingData = '0;
   bit                      txPending = 1'b0;
   logic [PAYLOAD_BITS-1:0] txPendingData = '0;
   bit                      forceRx = 1'b0;
   logic [PAYLOAD_BITS-1:0] forceRxData = '0;

   // Free-running user clock, 10 time units per period.
   always #5 clkUser = ~clkUser;

   leaf_user_port_adapter #(
      .PAYLOAD_BITS(PAYLOAD_BITS),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .CNT_BITS    (CNT_BITS)
   ) dut (
      .clk_user                 (clkUser),
      .reset_n                  (resetN),
      .dout_leaf_interface2user (doutIf2User),
      .vld_interface2user       (vldIf2User),
      .ack_user2interface       (ackUser2If),
      .m_data                   (mData),
      .m_valid                  (mValid),
      .m_ready                  (mReady),
      .s_data                   (sData),
      .s_valid                  (sValid),
      .s_ready                  (sReady),
      .din_leaf_user2interface  (dinUser2If),
      .vld_user2interface       (vldUser2If),
      .ack_interface2user       (ackIf2User),
      .rx_count                 (rxCount),
      .tx_count                 (txCount)
   );

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Compares every DUT output with what the reference model says it should show now.
   task automatic checkAll();
      bit ackExp;
      bit readyExp;
      if (!resetN) begin
         checkOutput("rst_ack", ackUser2If, 0);
         checkOutput("rst_m_valid", mValid, 0);
         checkOutput("rst_m_data", mData, 0);
         checkOutput("rst_s_ready", sReady, 0);
         checkOutput("rst_vld_out", vldUser2If, 0);
         checkOutput("rst_din", dinUser2If, 0);
         checkOutput("rst_rx_count", rxCount, 0);
         checkOutput("rst_tx_count", txCount, 0);
      end else begin
         ackExp   = outOfReset && (rxModel.size() < FIFO_DEPTH);
         readyExp = outOfReset && (txModel.size() < FIFO_DEPTH);
         checkOutput("ack", ackUser2If, ackExp);
         checkOutput("m_valid", mValid, rxModel.size() > 0);
         if (rxModel.size() > 0) checkOutput("m_data", mData, rxModel[0]);
         checkOutput("s_ready", sReady, readyExp);
         checkOutput("vld_out", vldUser2If, txModel.size() > 0);
         if (txModel.size() > 0) checkOutput("din", dinUser2If, txModel[0]);
         checkOutput("rx_count", rxCount, rxCountModel);
         checkOutput("tx_count", txCount, txCountModel);
      end
   endtask

   // One clock cycle: pick inputs (percent probabilities), advance the model at the
   // rising edge, then check outputs on the falling edge.
   task automatic applyStimulus(input int pRx, input int pMReady, input int pTx, input int pTxAck);
      bit ackExp, readyExp, rxPush, rxPop, txPush, txPop;
      if (!rxPending && ($urandom_range(99, 0) < pRx)) begin
         rxPending     = 1'b1;
         rxPendingData = forceRx ? forceRxData : $urandom;
         forceRx       = 1'b0;
      end
      if (!txPending && ($urandom_range(99, 0) < pTx)) begin
         txPending     = 1'b1;
         txPendingData = $urandom;
      end
      vldIf2User  = rxPending;
      doutIf2User = rxPending ? rxPendingData : $urandom;
      sValid      = txPending;
      sData       = txPending ? txPendingData : $urandom;
      mReady      = ($urandom_range(99, 0) < pMReady);
      ackIf2User  = ($urandom_range(99, 0) < pTxAck);
      @(posedge clkUser);
      if (resetN) begin
         ackExp   = outOfReset && (rxModel.size() < FIFO_DEPTH);
         readyExp = outOfReset && (txModel.size() < FIFO_DEPTH);
         rxPush   = rxPending && ackExp;
         rxPop    = (rxModel.size() > 0) && mReady;
         txPush   = txPending && readyExp;
         txPop    = (txModel.size() > 0) && ackIf2User;
         if (rxPop) void'(rxModel.pop_front());
         if (rxPush) begin
            rxModel.push_back(rxPendingData);
            rxPending    = 1'b0;
            rxCountModel = (rxCountModel + 1) % CNT_MOD;
         end
         if (txPop) begin
            void'(txModel.pop_front());
            txCountModel = (txCountModel + 1) % CNT_MOD;
         end
         if (txPush) begin
            txModel.push_back(txPendingData);
            txPending = 1'b0;
         end
         outOfReset = 1'b1;
      end
      @(negedge clkUser);
      checkAll();
   endtask

   // Asynchronous reset in the middle of a cycle, held for a few random cycles.
   task automatic pulseReset(input int holdCycles);
      #2 resetN = 1'b0;
      rxModel.delete();
      txModel.delete();
      rxCountModel = 0;
      txCountModel = 0;
      outOfReset   = 1'b0;
      #1 checkAll();
      @(negedge clkUser);
      repeat (holdCycles) applyStimulus(50, 50, 50, 50);
      resetN    = 1'b1;
      rxPending = 1'b0;
      txPending = 1'b0;
      vldIf2User = 1'b0;
      sValid     = 1'b0;
      #1 checkAll();
      @(negedge clkUser);
   endtask

   // Directed scenarios followed by random traffic, all checked against the model.
   initial begin
      #1 resetN = 1'b0;
      #1 checkAll();
      @(negedge clkUser);
      repeat (4) applyStimulus(50, 50, 50, 50);
      resetN    = 1'b1;
      rxPending = 1'b0;
      txPending = 1'b0;
      vldIf2User = 1'b0;
      sValid     = 1'b0;
      #1 checkAll();
      @(negedge clkUser);
      applyStimulus(0, 0, 0, 0);
      checkOutput("release_ack", ackUser2If, 1);
      checkOutput("release_s_ready", sReady, 1);

      $display("[TB] single RX word");
      forceRx     = 1'b1;
      forceRxData = 32'hDEADBEEF;
      applyStimulus(100, 100, 0, 0);
      checkOutput("single_m_data", mData, 32'hDEADBEEF);
      applyStimulus(0, 100, 0, 0);
      checkOutput("single_m_valid_low", mValid, 0);
      checkOutput("single_rx_count", rxCount, 1);

      $display("[TB] RX back-pressure");
      repeat (6) applyStimulus(100, 0, 0, 0);
      checkOutput("bp_ack_low", ackUser2If, 0);
      checkOutput("bp_rx_count", rxCount, 5);
      applyStimulus(100, 100, 0, 0);
      repeat (10) applyStimulus(0, 100, 0, 0);

      $display("[TB] TX full and steady level");
      repeat (5) applyStimulus(0, 0, 100, 0);
      checkOutput("tx_full_ready", sReady, 0);
      applyStimulus(0, 0, 0, 100);
      checkOutput("tx_pulse_ready", sReady, 1);
      applyStimulus(0, 0, 0, 0);
      repeat (2) applyStimulus(0, 0, 0, 100);
      repeat (8) applyStimulus(0, 0, 100, 100);
      repeat (8) applyStimulus(0, 0, 0, 100);

      $display("[TB] RX counter wrap");
      repeat (17) applyStimulus(100, 100, 0, 0);
      repeat (3) applyStimulus(0, 100, 0, 0);

      $display("[TB] random traffic");
      for (int i = 0; i < 300; i++) begin
         applyStimulus($urandom_range(100, 0), $urandom_range(100, 0),
                       $urandom_range(100, 0), $urandom_range(100, 0));
      end

      $display("[TB] reset mid-burst");
      repeat (8) applyStimulus(0, 100, 0, 100);
      repeat (3) applyStimulus(100, 0, 100, 0);
      pulseReset(3);
      checkOutput("post_rst_m_valid", mValid, 0);
      checkOutput("post_rst_vld_out", vldUser2If, 0);
      forceRx     = 1'b1;
      forceRxData = 32'h0BADF00D;
      applyStimulus(0, 0, 0, 0);
      applyStimulus(100, 0, 0, 0);
      checkOutput("post_rst_first_word", mData, 32'h0BADF00D);
      for (int i = 0; i < 150; i++) begin
         applyStimulus($urandom_range(100, 0), $urandom_range(100, 0),
                       $urandom_range(100, 0), $urandom_range(100, 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
